// File: rtl/pipe_stage_skid_pkg.sv
// Shared pipeline constants: inter-stage payload widths and skid-stage occupancy states.
package pipe_stage_skid_pkg;

  localparam int unsigned IFID_W  = 64;
  localparam int unsigned IDEX_W  = 152;
  localparam int unsigned EXMEM_W = 146;
  localparam int unsigned MEMWB_W = 104;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_e;

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones once reached.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en && (count_q != '1)) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (clr) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a 2-entry skid buffer, synchronous flush and
// a saturating stall-cycle counter. InReady is registered to cut the stall path.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int unsigned           WIDTH       = EXMEM_W,
  parameter logic [WIDTH-1:0]      FLUSH_VALUE = '0,
  parameter int unsigned           CNT_W       = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Flush,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] InData,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] OutData,
  output logic [1:0]       Occupancy,
  output logic [CNT_W-1:0] StallCount
);

  occ_state_e       state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic             in_fire, out_fire, stall;

  assign OutValid  = (state_q != ST_EMPTY);
  assign InReady   = in_ready_q;
  assign OutData   = main_q;
  assign Occupancy = 2'(state_q);

  assign in_fire  = InValid & in_ready_q;
  assign out_fire = OutValid & OutReady;
  assign stall    = OutValid & ~OutReady;

  // InData is only sampled on in_fire, so undriven payload with InValid=0 never lands in storage.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (Flush) begin
      state_d = ST_EMPTY;
      main_d  = FLUSH_VALUE;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_d  = InData;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_d = InData;
          end else if (in_fire) begin
            skid_d  = InData;
            state_d = ST_FULL;
          end else if (out_fire) begin
            main_d  = FLUSH_VALUE;
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: begin
          main_d  = FLUSH_VALUE;
          state_d = ST_EMPTY;
        end
      endcase
    end
    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= ST_EMPTY;
      main_q     <= FLUSH_VALUE;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (Clk),
    .clr   (Rst),
    .en    (stall),
    .count (StallCount)
  );

  a_in_ready_matches_state: assert property (
    @(posedge Clk) disable iff (Rst) in_ready_q == (state_q != ST_FULL));

endmodule
